piso_serializer: RTL and testbench

//   Parallel-in serial-out transmitter: the serializing end for the team's serial shift chains.

---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_shift_reg.sv | 32 +++
 rtl/piso_serializer.sv | 147 ++++++++++++++
 tb/tb_piso_serializer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types for the PISO serializer: FSM state encoding and counter width helper.
package piso_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  function automatic int piso_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit load/shift register; head is the bit currently presented on the serial line.
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             head
);

  logic [WIDTH-1:0] data_q;

  // Zero fill guarantees the head reads 0 once a frame has fully drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load_en) begin
      data_q <= load_data;
    end else if (shift_en) begin
      if (MSB_FIRST) data_q <= {data_q[WIDTH-2:0], 1'b0};
      else           data_q <= {1'b0, data_q[WIDTH-1:1]};
    end
  end

  assign head = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and back-to-back frames.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
//   S_IDLE   | waiting for a word, load_ready high
//   S_SHIFT  | data bits on dout, count = bit index
//   S_PARITY | parity trailer bit on dout
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int              CNT_W = piso_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`ifndef PISO_PARITY_EN
  localparam logic [CNT_W-1:0] PENULT = CNT_W'(WIDTH - 2);
`endif

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             dout_valid_q, busy_q, done_q, load_ready_q;
  logic             accept, last_bit, sr_load, sr_shift, sr_head;
  logic [WIDTH-1:0] sr_data;

  assign accept   = load_valid && load_ready_q;
  assign last_bit = (state == S_SHIFT) && (count == LAST);
  assign sr_shift = (state != S_IDLE);

`ifdef PISO_PARITY_EN
  localparam int HEAD = MSB_FIRST ? WIDTH - 1 : 0;
  logic parity_q;

  // On the last data bit the register is reloaded with the parity bit at its head.
  always_comb begin
    sr_data = din;
    if (!accept) begin
      sr_data       = '0;
      sr_data[HEAD] = parity_q;
    end
  end
  assign sr_load = accept || last_bit;
`else
  assign sr_data = din;
  assign sr_load = accept;
`endif

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (sr_load),
    .shift_en  (sr_shift),
    .load_data (sr_data),
    .head      (sr_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      count        <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
`ifdef PISO_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
`ifdef PISO_PARITY_EN
      if (accept) parity_q <= ^din;
`endif
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state        <= S_SHIFT;
            count        <= '0;
            dout_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            load_ready_q <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (count != LAST) begin
            count <= count + CNT_W'(1);
`ifndef PISO_PARITY_EN
            if (count == PENULT) begin
              done_q       <= 1'b1;
              load_ready_q <= 1'b1;
            end
`endif
          end
`ifdef PISO_PARITY_EN
          else begin
            state        <= S_PARITY;
            done_q       <= 1'b1;
            load_ready_q <= 1'b1;
          end
`else
          else if (accept) begin
            count        <= '0;
            load_ready_q <= 1'b0;
          end else begin
            state        <= S_IDLE;
            count        <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
          end
`endif
        end
        S_PARITY: begin
          count <= '0;
          if (accept) begin
            state        <= S_SHIFT;
            load_ready_q <= 1'b0;
          end else begin
            state        <= S_IDLE;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign load_ready = load_ready_q;
  assign dout       = sr_head;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: MSB-first and LSB-first instances share one input stream.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         load_valid;
  logic m_load_ready, m_dout, m_dout_valid, m_busy, m_done;
  logic l_load_ready, l_dout, l_dout_valid, l_busy, l_done;

  typedef struct packed {
    logic d;
    logic last;
  } exp_t;

  exp_t q_m[$];
  exp_t q_l[$];
  exp_t em, el;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(m_load_ready), .dout(m_dout), .dout_valid(m_dout_valid),
    .busy(m_busy), .done(m_done)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(l_load_ready), .dout(l_dout), .dout_valid(l_dout_valid),
    .busy(l_busy), .done(l_done)
  );

  function automatic void push_word(input logic [W-1:0] w);
    logic lst;
    for (int k = 0; k < W; k++) begin
`ifdef PISO_PARITY_EN
      lst = 1'b0;
`else
      lst = (k == W - 1);
`endif
      q_m.push_back(exp_t'{d: w[W-1-k], last: lst});
      q_l.push_back(exp_t'{d: w[k], last: lst});
    end
`ifdef PISO_PARITY_EN
    q_m.push_back(exp_t'{d: ^w, last: 1'b1});
    q_l.push_back(exp_t'{d: ^w, last: 1'b1});
`endif
  endfunction

  // Scoreboard: every framed bit must match the next expected bit and its done flag.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (m_dout_valid) begin
        if (q_m.size() == 0) begin
          errors++;
          $display("FAIL msb_unexpected_bit dout=%b done=%b queue empty", m_dout, m_done);
        end else begin
          em = q_m.pop_front();
          if (m_dout !== em.d || m_done !== em.last) begin
            errors++;
            $display("FAIL msb_bit got dout=%b done=%b want dout=%b done=%b", m_dout, m_done, em.d, em.last);
          end
        end
      end else if (m_dout !== 1'b0 || m_done !== 1'b0) begin
        errors++;
        $display("FAIL msb_idle got dout=%b done=%b want 0 0", m_dout, m_done);
      end
      checks++;
      if (l_dout_valid) begin
        if (q_l.size() == 0) begin
          errors++;
          $display("FAIL lsb_unexpected_bit dout=%b done=%b queue empty", l_dout, l_done);
        end else begin
          el = q_l.pop_front();
          if (l_dout !== el.d || l_done !== el.last) begin
            errors++;
            $display("FAIL lsb_bit got dout=%b done=%b want dout=%b done=%b", l_dout, l_done, el.d, el.last);
          end
        end
      end else if (l_dout !== 1'b0 || l_done !== 1'b0) begin
        errors++;
        $display("FAIL lsb_idle got dout=%b done=%b want 0 0", l_dout, l_done);
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    din        = w;
    load_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (m_load_ready) begin
        push_word(w);
        ok = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout word=%h load_ready=%b want 1", w, m_load_ready);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    load_valid = 1'b0;
    din        = '0;
    #12;
    checks++;
    if ({m_load_ready, m_dout, m_dout_valid, m_busy, m_done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_msb got %b want 10000", {m_load_ready, m_dout, m_dout_valid, m_busy, m_done});
    end
    checks++;
    if ({l_load_ready, l_dout, l_dout_valid, l_busy, l_done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_lsb got %b want 10000", {l_load_ready, l_dout, l_dout_valid, l_busy, l_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_msb_a5();
    send(8'hA5);
    load_valid = 1'b0;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (m_dout_valid !== 1'b1 || m_busy !== 1'b1) begin
        errors++;
        $display("FAIL a5_frame cycle=%0d valid=%b busy=%b want 1 1", c, m_dout_valid, m_busy);
      end
    end
    @(negedge clk);
    checks++;
    if ({m_dout_valid, m_busy, m_load_ready} !== 3'b001) begin
      errors++;
      $display("FAIL a5_end got valid/busy/ready=%b want 001", {m_dout_valid, m_busy, m_load_ready});
    end
  endtask

  task automatic test_lsb_01();
    send(8'h01);
    load_valid = 1'b0;
    for (int c = 1; c <= W; c++) begin
      @(negedge clk);
      checks++;
      if (l_dout_valid !== 1'b1 || l_dout !== (c == 1)) begin
        errors++;
        $display("FAIL lsb01 cycle=%0d valid=%b dout=%b want 1 %b", c, l_dout_valid, l_dout, c == 1);
      end
    end
    repeat (FRAME - W + 1) @(negedge clk);
    checks++;
    if (l_dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL lsb01_end valid=%b want 0", l_dout_valid);
    end
  endtask

  task automatic test_back_to_back();
    send(8'hFF);
    fork
      begin
        send(8'h00);
        load_valid = 1'b0;
      end
      begin
        for (int c = 1; c <= 2 * FRAME; c++) begin
          @(negedge clk);
          checks++;
          if (m_dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap cycle=%0d valid=%b want 1", c, m_dout_valid);
          end
        end
      end
    join
    @(negedge clk);
    checks++;
    if (m_dout_valid !== 1'b0 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end valid=%b busy=%b want 0 0", m_dout_valid, m_busy);
    end
  endtask

  task automatic test_busy_ignore();
    send(8'hC6);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    din        = 8'h3C;
    load_valid = 1'b1;
    checks++;
    if (m_load_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready load_ready=%b want 0", m_load_ready);
    end
    @(negedge clk);
    load_valid = 1'b0;
    for (int c = 5; c <= FRAME; c++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_dout_valid !== 1'b0 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignored valid=%b busy=%b want 0 0", m_dout_valid, m_busy);
    end
  endtask

  task automatic test_reset_abort();
    send(8'hE7);
    load_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_load_ready, m_dout, m_dout_valid, m_busy, m_done} !== 5'b10000) begin
      errors++;
      $display("FAIL abort_msb got %b want 10000", {m_load_ready, m_dout, m_dout_valid, m_busy, m_done});
    end
    checks++;
    if ({l_load_ready, l_dout, l_dout_valid, l_busy, l_done} !== 5'b10000) begin
      errors++;
      $display("FAIL abort_lsb got %b want 10000", {l_load_ready, l_dout, l_dout_valid, l_busy, l_done});
    end
    q_m.delete();
    q_l.delete();
    repeat (6) begin
      @(posedge clk);
      #1;
      checks++;
      if (m_done !== 1'b0 || l_done !== 1'b0) begin
        errors++;
        $display("FAIL abort_done msb=%b lsb=%b want 0 0", m_done, l_done);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_load_ready, m_dout_valid, m_busy} !== 3'b100) begin
      errors++;
      $display("FAIL abort_release got %b want 100", {m_load_ready, m_dout_valid, m_busy});
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    send(8'h07);
    load_valid = 1'b0;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (c == FRAME && (m_dout !== 1'b1 || m_done !== 1'b1 || m_dout_valid !== 1'b1)) begin
        errors++;
        $display("FAIL parity_bit dout=%b done=%b valid=%b want 1 1 1", m_dout, m_done, m_dout_valid);
      end else if (c < FRAME && m_done !== 1'b0) begin
        errors++;
        $display("FAIL parity_early_done cycle=%0d done=%b want 0", c, m_done);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_msb_a5();
    test_lsb_01();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      errors++;
      $display("FAIL leftover_bits msb=%0d lsb=%0d want 0 0", q_m.size(), q_l.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
